regfile_writeback: RTL and testbench

- Write-back end of the multicycle datapath's register-file interface.
- Operand registers capture register-file read data. This block carries results back into the register file.
- Accepts write-back requests from the control FSM, selects between the ALUOUT value and the memory data value, and buffers up to two pending writes.
- Drives the register file's single write port with a write/grant handshake, and reports pending writes so the control FSM can stall dependent reads.

---
 rtl/regfile_writeback_pkg.sv | 17 +
 rtl/wb_fifo2.sv | 111 +++++++++++
 rtl/regfile_writeback.sv | 93 +++++++++
 tb/tb_regfile_writeback.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the register-file write-back path: default widths,
// write-back source encoding and the write buffer's occupancy states.
package regfile_writeback_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_MEM = 1'b1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry {dst, data} write buffer with an occupancy FSM.
//
//   state | meaning
//   EMPTY | no write pending
//   ONE   | one write pending, slot rd_ptr holds it
//   FULL  | two writes pending, rd_ptr is the older one
//
// Besides the storage it reports what the head will be after the coming
// edge (nxt_*), so the owner can register the head without a cycle of lag.
module wb_fifo2
    import regfile_writeback_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [ADDR_W-1:0]      push_dst,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output occ_t                   state,
    output logic                   nxt_valid,
    output logic [ADDR_W-1:0]      nxt_dst,
    output logic [DATA_W-1:0]      nxt_data,
    output logic [1:0]             ent_valid,
    output logic [1:0][ADDR_W-1:0] ent_dst
);

    logic [1:0][DATA_W-1:0] ent_data;
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic                   push_ok;
    logic                   pop_ok;

    assign push_ok = push && (state != FULL);
    assign pop_ok  = pop && (state != EMPTY);

    // Occupancy FSM, pointers and storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            ent_dst  <= '0;
            ent_data <= '0;
        end else begin
            if (push_ok) begin
                ent_dst[wr_ptr]  <= push_dst;
                ent_data[wr_ptr] <= push_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case (state)
                EMPTY:   if (push_ok) state <= ONE;
                ONE: begin
                    if (push_ok && !pop_ok)      state <= FULL;
                    else if (pop_ok && !push_ok) state <= EMPTY;
                end
                FULL:    if (pop_ok) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    // Head as it will stand after the coming edge.
    always_comb begin
        nxt_valid = 1'b0;
        nxt_dst   = ent_dst[rd_ptr];
        nxt_data  = ent_data[rd_ptr];
        case (state)
            EMPTY: begin
                if (push_ok) begin
                    nxt_valid = 1'b1;
                    nxt_dst   = push_dst;
                    nxt_data  = push_data;
                end
            end
            ONE: begin
                if (pop_ok && push_ok) begin
                    nxt_valid = 1'b1;
                    nxt_dst   = push_dst;
                    nxt_data  = push_data;
                end else if (!pop_ok) begin
                    nxt_valid = 1'b1;
                end
            end
            FULL: begin
                nxt_valid = 1'b1;
                if (pop_ok) begin
                    nxt_dst  = ent_dst[~rd_ptr];
                    nxt_data = ent_data[~rd_ptr];
                end
            end
            default: nxt_valid = 1'b0;
        endcase
    end

    // Which slots currently hold a pending write.
    always_comb begin
        ent_valid = 2'b00;
        case (state)
            ONE:     ent_valid[rd_ptr] = 1'b1;
            FULL:    ent_valid = 2'b11;
            default: ent_valid = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back front of the register file: picks the result source, drops
// writes to the hardwired zero register, buffers up to two writes and
// presents them to the single write port with a we/grant handshake.
// Hazard flags let decode stall reads of registers with writes in flight.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic              wb_sel,
    input  logic [ADDR_W-1:0] wb_dst,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] memdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_grant,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              pend1,
    output logic              pend2,
    output logic              busy
);

    occ_t                   state;
    logic                   push;
    logic                   pop;
    logic                   zero_drop;
    logic [DATA_W-1:0]      sel_data;
    logic                   nxt_valid;
    logic [ADDR_W-1:0]      nxt_dst;
    logic [DATA_W-1:0]      nxt_data;
    logic [1:0]             ent_valid;
    logic [1:0][ADDR_W-1:0] ent_dst;

    assign wb_ready  = (state != FULL);
    assign busy      = (state != EMPTY);
    assign sel_data  = (wb_sel == WB_SRC_MEM) ? memdata : aluout;
    // A zero-register write still completes its handshake; it just never lands.
    assign zero_drop = ZERO_REG && (wb_dst == '0);
    assign push      = wb_valid && wb_ready && !zero_drop;
    assign pop       = rf_we && rf_grant;

    wb_fifo2 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_dst  (wb_dst),
        .push_data (sel_data),
        .pop       (pop),
        .state     (state),
        .nxt_valid (nxt_valid),
        .nxt_dst   (nxt_dst),
        .nxt_data  (nxt_data),
        .ent_valid (ent_valid),
        .ent_dst   (ent_dst)
    );

    // Registered copy of the buffer head; address/data hold while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= nxt_valid;
            if (nxt_valid) begin
                rf_waddr <= nxt_dst;
                rf_wdata <= nxt_data;
            end
        end
    end

    // Hazard compare against every pending entry, including the one on the port.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (ent_valid[i] && (ent_dst[i] == rd_addr1)) pend1 = 1'b1;
            if (ent_valid[i] && (ent_dst[i] == rd_addr2)) pend2 = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios followed by random traffic,
// all compared against a queue-based model of the pending writes.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic        wb_sel = 1'b0;
    logic [2:0]  wb_dst = '0;
    logic [15:0] aluout = '0;
    logic [15:0] memdata = '0;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_grant = 1'b0;
    logic [2:0]  rd_addr1 = 3'd4;
    logic [2:0]  rd_addr2 = 3'd6;
    logic        pend1;
    logic        pend2;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Pending writes as {dst, data}, oldest first.
    logic [18:0] q[$];

    always #5 clk = ~clk;

    regfile_writeback #(
        .DATA_W   (16),
        .ADDR_W   (3),
        .ZERO_REG (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_sel   (wb_sel),
        .wb_dst   (wb_dst),
        .aluout   (aluout),
        .memdata  (memdata),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rf_grant (rf_grant),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .pend1    (pend1),
        .pend2    (pend2),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, compare every output
    // with the model, then advance the model across the rising edge.
    task automatic step(input logic v, input logic sel, input logic [2:0] dst,
                        input logic [15:0] alu, input logic [15:0] mem,
                        input logic gnt, input logic [2:0] ra1, input logic [2:0] ra2);
        int  n;
        logic p1, p2;
        @(negedge clk);
        wb_valid = v;   wb_sel  = sel; wb_dst   = dst;
        aluout   = alu; memdata = mem; rf_grant = gnt;
        rd_addr1 = ra1; rd_addr2 = ra2;
        #1;
        n  = q.size();
        p1 = 1'b0;
        p2 = 1'b0;
        foreach (q[i]) begin
            if (q[i][18:16] == ra1) p1 = 1'b1;
            if (q[i][18:16] == ra2) p2 = 1'b1;
        end
        check("wb_ready", wb_ready, n < 2);
        check("rf_we",    rf_we,    n > 0);
        check("busy",     busy,     n > 0);
        check("pend1",    pend1,    p1);
        check("pend2",    pend2,    p2);
        if (n > 0) begin
            check("rf_waddr", rf_waddr, q[0][18:16]);
            check("rf_wdata", rf_wdata, q[0][15:0]);
        end
        @(posedge clk);
        if (n > 0 && gnt) void'(q.pop_front());
        if (v && n < 2 && dst != 3'd0) q.push_back({dst, sel ? mem : alu});
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_we",    rf_we,    1'b0);
        check("rst_waddr", rf_waddr, 3'd0);
        check("rst_wdata", rf_wdata, 16'h0);
        check("rst_busy",  busy,     1'b0);
        check("rst_pend",  {pend1, pend2}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", wb_ready, 1'b1);

        // Single ALU write
        step(1, 0, 3'd3, 16'h1234, 16'h0, 1, 4, 6);
        #2;
        check("t1_we",    rf_we,    1'b1);
        check("t1_waddr", rf_waddr, 3'd3);
        check("t1_wdata", rf_wdata, 16'h1234);
        step(0, 0, 3'd0, 16'h0, 16'h0, 1, 4, 6);
        #2;
        check("t1_we_off", rf_we, 1'b0);
        check("t1_busy",   busy,  1'b0);

        // Memory source, captured at accept
        step(1, 1, 3'd5, 16'h0, 16'hBEEF, 0, 4, 6);
        step(0, 1, 3'd5, 16'h0, 16'h0000, 0, 4, 6);
        #2;
        check("t2_wdata", rf_wdata, 16'hBEEF);
        step(0, 0, 3'd0, 16'h0, 16'h0, 1, 4, 6);

        // Backpressure and full
        step(1, 0, 3'd1, 16'h0001, 16'h0, 0, 4, 6);
        step(1, 0, 3'd2, 16'h0002, 16'h0, 0, 4, 6);
        #2;
        check("t3_ready_full", wb_ready, 1'b0);
        step(1, 0, 3'd7, 16'h0003, 16'h0, 0, 4, 6);
        step(1, 0, 3'd7, 16'h0003, 16'h0, 1, 4, 6);
        #2;
        check("t3_second", rf_waddr, 3'd2);
        step(1, 0, 3'd7, 16'h0003, 16'h0, 1, 4, 6);
        #2;
        check("t3_third", rf_waddr, 3'd7);
        step(0, 0, 3'd0, 16'h0, 16'h0, 1, 4, 6);

        // Same-address ordering and hazard flags
        step(1, 0, 3'd4, 16'hAAAA, 16'h0, 0, 4, 6);
        step(1, 0, 3'd4, 16'h5555, 16'h0, 0, 4, 6);
        #2;
        check("t4_pend1", pend1, 1'b1);
        check("t4_pend2", pend2, 1'b0);
        check("t4_first", rf_wdata, 16'hAAAA);
        step(0, 0, 3'd0, 16'h0, 16'h0, 1, 4, 6);
        #2;
        check("t4_last", rf_wdata, 16'h5555);
        step(0, 0, 3'd0, 16'h0, 16'h0, 1, 4, 6);
        #2;
        check("t4_pend1_clr", pend1, 1'b0);

        // Register zero is accepted and dropped
        step(1, 0, 3'd0, 16'hFFFF, 16'h0, 0, 0, 6);
        #2;
        check("t5_we",   rf_we, 1'b0);
        check("t5_busy", busy,  1'b0);
        step(0, 0, 3'd0, 16'h0, 16'h0, 1, 4, 6);

        // Async reset mid-operation
        step(1, 0, 3'd1, 16'h0011, 16'h0, 0, 1, 2);
        step(1, 0, 3'd2, 16'h0022, 16'h0, 0, 1, 2);
        @(negedge clk);
        wb_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_we",   rf_we, 1'b0);
        check("t6_busy", busy,  1'b0);
        check("t6_pend", {pend1, pend2}, 2'b00);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(0, 0, 3'd0, 16'h0, 16'h0, 1, 1, 2);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)),
                 16'($urandom_range(0, 65535)), $urandom_range(0, 1) == 1,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
